// File: rtl/ex_stage.sv
// EX pipeline stage: forwarding, ALU, branch resolution and a 4-step byte-serial
// multiplier that stalls upstream, feeding the EX/MEM register.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] sign_ext,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [5:0]  funct,
    input  logic        regDest,
    input  logic        branch,
    input  logic        MemRead,
    input  logic        MemtoReg,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic [1:0]  ALUOp,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [31:0] branch_target_out,
    output logic [4:0]  dest_out,
    output logic        MemRead_out,
    output logic        MemtoReg_out,
    output logic        MemWrite_out,
    output logic        RegWrite_out,
    output logic        branch_taken_out,
    output logic        stall_out
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RLEN = 5;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;

    logic              exmem_fwd_ok, wb_fwd_ok;
    logic [XLEN-1:0]   fwd_a, fwd_b, op2, alu_res, step;
    logic [7:0]        b_sel;
    logic [4:0]        shamt;
    logic              is_mult, stall, load_bubble, load_exec, use_acc;

    logic [XLEN-1:0]   alu_d, store_d, target_d;
    logic [RLEN-1:0]   dest_d;
    logic              mem_read_d, mem_to_reg_d, mem_write_d, reg_write_d, taken_d;

    // Forwarding: a load in EX/MEM has no value yet, so only ALU results forward from there
    assign exmem_fwd_ok = RegWrite_out && !MemtoReg_out && (dest_out != 5'd0);
    assign wb_fwd_ok    = wb_RegWrite && (wb_rd != 5'd0);

    assign fwd_a = (exmem_fwd_ok && (dest_out == rs_addr)) ? alu_result_out :
                   (wb_fwd_ok && (wb_rd == rs_addr))       ? wb_data : rs_val;
    assign fwd_b = (exmem_fwd_ok && (dest_out == rt_addr)) ? alu_result_out :
                   (wb_fwd_ok && (wb_rd == rt_addr))       ? wb_data : rt_val;

    assign op2     = ALUSrc ? sign_ext : fwd_b;
    assign is_mult = (ALUOp == 2'b10) && (funct == F_MULT);

    // One byte of the latched B operand per step, shifted into its weight
    assign shamt = {cnt_q, 3'b000};
    assign b_sel = b_q[shamt +: 8];
    assign step  = (a_q * {24'd0, b_sel}) << shamt;

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            2'b00:   alu_res = fwd_a + op2;
            2'b01:   alu_res = fwd_a - op2;
            2'b11:   alu_res = fwd_a | op2;
            default: begin
                case (funct)
                    F_ADD:   alu_res = fwd_a + op2;
                    F_SUB:   alu_res = fwd_a - op2;
                    F_AND:   alu_res = fwd_a & op2;
                    F_OR:    alu_res = fwd_a | op2;
                    F_SLT:   alu_res = {31'd0, $signed(fwd_a) < $signed(op2)};
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        stall       = 1'b0;
        load_bubble = 1'b0;
        load_exec   = 1'b0;
        use_acc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mult) begin
                    stall       = 1'b1;
                    a_d         = fwd_a;
                    b_d         = fwd_b;
                    acc_d       = '0;
                    cnt_d       = 2'd0;
                    state_d     = MUL;
                    load_bubble = 1'b1;
                end else begin
                    load_exec = 1'b1;
                end
            end
            MUL: begin
                acc_d = acc_q + step;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = IDLE;
                    load_exec = 1'b1;
                    use_acc   = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_out = stall && !reset;

    // EX/MEM next values: bubble on mult entry, hold while stalled, else capture
    always_comb begin
        alu_d        = alu_result_out;
        store_d      = store_data_out;
        target_d     = branch_target_out;
        dest_d       = dest_out;
        mem_read_d   = MemRead_out;
        mem_to_reg_d = MemtoReg_out;
        mem_write_d  = MemWrite_out;
        reg_write_d  = RegWrite_out;
        taken_d      = branch_taken_out;
        if (load_bubble) begin
            alu_d        = '0;
            store_d      = '0;
            target_d     = '0;
            dest_d       = '0;
            mem_read_d   = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            taken_d      = 1'b0;
        end else if (load_exec) begin
            alu_d        = use_acc ? acc_d : alu_res;
            store_d      = fwd_b;
            target_d     = pc_plus4 + (sign_ext << 2);
            dest_d       = regDest ? rd_addr : rt_addr;
            mem_read_d   = MemRead;
            mem_to_reg_d = MemtoReg;
            mem_write_d  = MemWrite;
            reg_write_d  = RegWrite;
            taken_d      = branch && (fwd_a == fwd_b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            acc_q             <= '0;
            a_q               <= '0;
            b_q               <= '0;
            alu_result_out    <= '0;
            store_data_out    <= '0;
            branch_target_out <= '0;
            dest_out          <= '0;
            MemRead_out       <= 1'b0;
            MemtoReg_out      <= 1'b0;
            MemWrite_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            branch_taken_out  <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            acc_q             <= acc_d;
            a_q               <= a_d;
            b_q               <= b_d;
            alu_result_out    <= alu_d;
            store_data_out    <= store_d;
            branch_target_out <= target_d;
            dest_out          <= dest_d;
            MemRead_out       <= mem_read_d;
            MemtoReg_out      <= mem_to_reg_d;
            MemWrite_out      <= mem_write_d;
            RegWrite_out      <= reg_write_d;
            branch_taken_out  <= taken_d;
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset (one clock; reset is asynchronous and active-high).
REQ-002 SHALL have: rs_val, rt_val, sign_ext, pc_plus4  in  32 each  operands, immediate and PC+4 from the ID/EX register.
REQ-003 SHALL have: rs_addr, rt_addr, rd_addr  in  5 each  register numbers from ID/EX; funct  in  6  instruction[5:0].
REQ-004 SHALL have: regDest, branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  in  1 each, and ALUOp  in  2, as control bits from ID/EX.
REQ-005 SHALL have: wb_RegWrite  in  1, wb_rd  in  5, wb_data  in  32  MEM/WB write-back forwarding source.
REQ-006 SHALL have: alu_result_out, store_data_out, branch_target_out  out  32 each; dest_out  out  5; MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out, branch_taken_out  out  1 each; all registered (EX/MEM register).
REQ-007 SHALL have: stall_out  out  1  combinational; when high, upstream PC, IF/ID and ID/EX SHALL hold.

Function
REQ-008 Forwarded A SHALL be EX/MEM alu_result_out if RegWrite_out, !MemtoReg_out, dest_out!=0, dest_out==rs_addr; else wb_data if wb_RegWrite, wb_rd!=0, wb_rd==rs_addr; else rs_val. EX/MEM has priority.
REQ-009 Forwarded B SHALL use the same rule keyed on rt_addr; store_data_out SHALL capture forwarded B.
REQ-010 ALU operand 2 SHALL be sign_ext if ALUSrc else forwarded B.
REQ-011 Operation: ALUOp 00 add; 01 sub; 11 or; 10 decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0), 011000 mult (low 32 bits); any other funct -> result 0.
REQ-012 Add/sub/mult SHALL wrap modulo 2^32; no overflow flag or trap.
REQ-013 dest_out SHALL capture rd_addr if regDest else rt_addr.
REQ-014 branch_taken_out SHALL capture branch AND (forwarded A == forwarded B); branch_target_out SHALL capture pc_plus4 + (sign_ext << 2), wrapping.
REQ-015 Single-cycle ops: EX/MEM outputs SHALL update on every rising edge where stall_out is low; latency 1 cycle.
REQ-016 Mult FSM states IDLE, MUL with 2-bit counter cnt.
REQ-017 IDLE with decoded mult: stall_out=1; at edge latch forwarded A/B, clear accumulator, go MUL cnt=0, load EX/MEM with a bubble (all control outputs 0, data outputs 0).
REQ-018 MUL: each edge SHALL add (A * B[8*cnt+7:8*cnt]) << 8*cnt into accumulator (32-bit) and increment cnt; stall_out=1 while cnt<3.
REQ-019 MUL cnt==3: stall_out=0; at edge perform final step, write accumulator result and current control bits to EX/MEM, return IDLE.
REQ-020 Mult total: 4 stall cycles, result visible in EX/MEM 5 edges after the mult enters EX.
REQ-021 Inputs changing while in MUL SHALL not affect the result (operands latched); control taken at final edge.
REQ-022 Mult with RegWrite=0 SHALL still run the full sequence.

Reset
REQ-023 reset high SHALL immediately force all outputs to 0, FSM to IDLE, cnt and accumulator to 0, independent of clk.
REQ-024 reset during MUL SHALL abandon the multiply; stall_out SHALL read 0 while reset is high and no mult is presented in IDLE.

Verification
REQ-025 add: rs_val=5, rt_val=7, ALUOp=10, funct=100000, regDest=1, rd=3 -> next edge alu_result_out=12, dest_out=3.
REQ-026 EX/MEM forward: add r3 then sub r4=r3-r1 (r1=2) -> second result 10 using forwarded 12, not stale rs_val.
REQ-027 both sources match rs: EX/MEM=9, wb_data=4 -> A=9; rs_addr=0 with matches -> rs_val used.
REQ-028 mult 0x00010003*0x00000100: stall_out high 4 cycles, bubble in EX/MEM, then alu_result_out=0x01000300; 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-029 beq forwarded A=B=6, sign_ext=4, pc_plus4=0x100 -> branch_taken_out=1, branch_target_out=0x110; A!=B -> 0.
REQ-030 reset asserted at MUL cnt=1 -> outputs 0 immediately, stall_out 0; after release a fresh add completes in 1 cycle.
